// File: rtl/gsim_pkg.sv
// Shared constants and state encoding for the 16-unknown Gauss-Seidel solver.
// Kept separate so the future solver top can decode the scheduler state directly.
package gsim_pkg;

  localparam int N      = 16;
  localparam int IDX_W  = 4;
  localparam int ITER_W = 8;
  localparam int FRAC_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_OUT   = 3'd5
  } state_e;

endpackage

// File: rtl/gsim_idx_cnt.sv
// Index counter 0..CNT_N-1 with synchronous clear, wrap-on-increment and terminal-count flag.
// The scheduler uses one each for the b write address, the update index and the output index.
module gsim_idx_cnt
  import gsim_pkg::*;
#(
  parameter int CNT_N = gsim_pkg::N,
  parameter int CNT_W = gsim_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT_N - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: flops are written only with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/gsim_sched.sv
// Gauss-Seidel sequencing controller: loads b, issues one x-update at a time in index
// order, tracks per-sweep max delta for convergence, then streams the solution out.
module gsim_sched
  import gsim_pkg::*;
#(
  parameter int              N        = gsim_pkg::N,
  parameter int              IDX_W    = gsim_pkg::IDX_W,
  parameter int              ITER_W   = gsim_pkg::ITER_W,
  parameter int              MAX_ITER = 100,
  parameter logic [31:0]     TOL      = 32'h0000_0010
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_en,
  output logic                b_we,
  output logic [IDX_W-1:0]    b_addr,
  output logic                x_clr,
  output logic                upd_req,
  output logic [IDX_W-1:0]    upd_idx,
  input  logic                upd_done,
  input  logic [2*FRAC_W-1:0] upd_delta,
  output logic                out_valid,
  output logic [IDX_W-1:0]    out_idx,
  output logic                busy,
  output logic                converged,
  output logic [ITER_W-1:0]   iter_cnt
);

  state_e              r_state;
  logic                r_x_clr;
  logic                r_upd_req;
  logic                r_out_valid;
  logic                r_converged;
  logic [ITER_W-1:0]   r_iter;
  logic [2*FRAC_W-1:0] r_sweep_max;

  logic                w_accept;
  logic                w_done;
  logic                w_b_tc;
  logic                w_idx_tc;
  logic                w_out_tc;
  logic [ITER_W-1:0]   w_iter_new;
  logic                w_conv;
  logic                w_stop;

  assign w_accept   = in_en && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_done     = upd_done && (r_state == S_WAIT);
  assign w_iter_new = r_iter + 1'b1;
  // The first sweep starts from x=0, so its small deltas never prove convergence.
  assign w_conv     = (w_iter_new >= ITER_W'(2)) && (r_sweep_max < TOL);
  assign w_stop     = w_conv || (w_iter_new == ITER_W'(MAX_ITER));

  gsim_idx_cnt #(.CNT_N(N), .CNT_W(IDX_W)) u_b_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_clr ((r_state == S_IDLE) && !in_en),
    .i_inc (w_accept),
    .o_cnt (b_addr),
    .o_tc  (w_b_tc)
  );

  gsim_idx_cnt #(.CNT_N(N), .CNT_W(IDX_W)) u_idx_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (r_state == S_CHECK),
    .i_inc (w_done),
    .o_cnt (upd_idx),
    .o_tc  (w_idx_tc)
  );

  gsim_idx_cnt #(.CNT_N(N), .CNT_W(IDX_W)) u_out_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (r_state == S_CHECK),
    .i_inc (r_state == S_OUT),
    .o_cnt (out_idx),
    .o_tc  (w_out_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_x_clr     <= 1'b0;
      r_upd_req   <= 1'b0;
      r_out_valid <= 1'b0;
      r_converged <= 1'b0;
      r_iter      <= '0;
      r_sweep_max <= '0;
    end else begin
      r_x_clr   <= 1'b0;
      r_upd_req <= 1'b0;
      unique case (r_state)
        S_IDLE: if (in_en) begin
          r_state     <= S_LOAD;
          r_x_clr     <= 1'b1;
          r_iter      <= '0;
          r_converged <= 1'b0;
          r_sweep_max <= '0;
        end
        S_LOAD: if (in_en && w_b_tc) begin
          r_state   <= S_ISSUE;
          r_upd_req <= 1'b1;
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: if (upd_done) begin
          if (upd_delta > r_sweep_max) r_sweep_max <= upd_delta;
          if (w_idx_tc) begin
            r_state <= S_CHECK;
          end else begin
            r_state   <= S_ISSUE;
            r_upd_req <= 1'b1;
          end
        end
        S_CHECK: begin
          r_iter      <= w_iter_new;
          r_converged <= w_conv;
          if (w_stop) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
          end else begin
            r_sweep_max <= '0;
            r_state     <= S_ISSUE;
            r_upd_req   <= 1'b1;
          end
        end
        S_OUT: if (w_out_tc) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign b_we      = w_accept;
  assign x_clr     = r_x_clr;
  assign upd_req   = r_upd_req;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != S_IDLE);
  assign converged = r_converged;
  assign iter_cnt  = r_iter;

endmodule
